sa_gemm_ref_model: RTL and testbench
====================================

Name: sa_gemm_ref_model

Overview:
- Parametrised, cycle-accurate golden model of a weight-stationary systolic GEMM tile: out[i] = sum_j in[j]*W[j][i].
- Successor to the combinational vector×matrix model. Adds run-time weight loading, valid/ready streaming, fixed pipeline latency, configurable accumulator width and a tile-accumulate mode.
- Instantiated beside the systolic array in FV and simulation benches as the scoreboard reference.

Parameters:
- SA_SIZE, 3, array dimension; vectors have SA_SIZE lanes, W is SA_SIZE x SA_SIZE.
- WEIGHT_ACTIVATION_SIZE, 8, bit width of each weight and activation element.
- ACC_SIZE, 8, output/accumulator lane width; all arithmetic is mod 2^ACC_SIZE.
- LATENCY, 2, cycles from input accept to out_valid with no stall; legal range 1..8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- w_valid  in  1  weight row write request.
- w_ready  out  1  weight write accepted when w_valid && w_ready.
- w_row_idx  in  $clog2(SA_SIZE)  row j being written.
- w_row  in  SA_SIZE x WEIGHT_ACTIVATION_SIZE  W[j][0..SA_SIZE-1].
- in_valid  in  1  activation beat valid.
- in_ready  out  1  activation beat accepted when in_valid && in_ready.
- in_data  in  SA_SIZE x WEIGHT_ACTIVATION_SIZE  activation vector.
- in_last  in  1  last beat of tile.
- acc_mode  in  1  0 = per-beat output, 1 = accumulate across tile; sampled on the first beat of a tile.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_data  out  SA_SIZE x ACC_SIZE  result vector.
- out_last  out  1  tile end marker.
- weights_loaded  out  1  all SA_SIZE rows written since reset.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_last=0, weights_loaded=0, in_ready=0, w_ready=1.
  - Row-written mask, pipeline valids and accumulator are cleared.
  - FSM enters EMPTY.
- FSM states and transitions:
  - EMPTY: no rows written. A weight write sets mask[w_row_idx]; go to LOADING.
  - LOADING: rows may be written in any order. Rewriting a row overwrites it. When the mask is all-ones (same edge as the final write), go to READY and assert weights_loaded.
  - READY: activations accepted. A weight write is allowed only while w_ready=1, and the new row is used by beats accepted after the write edge.
- w_ready = 1 only when the pipeline is empty and no accumulate tile is open. It is otherwise 0, so weights never change under in-flight data.
- w_row_idx >= SA_SIZE with w_valid: the write is ignored but still handshakes. Tag this as an assertion target.
- in_ready = (state==READY) && !stall. stall = out_valid && !out_ready. While stalled, the whole pipeline freezes and out_data/out_last hold stable.
- Arithmetic: each product is computed at full 2*WEIGHT_ACTIVATION_SIZE width, summed, then truncated to ACC_SIZE LSBs. Wrap-around is silent; unsigned only.
- Mode 0: each accepted beat produces exactly one output exactly LATENCY cycles later when unstalled. out_last = in_last of that beat.
- Mode 1:
  - Per-lane dot products accumulate mod 2^ACC_SIZE from the first beat.
  - Only the in_last beat produces an output: the tile sum, out_last=1, LATENCY cycles after that beat. Intermediate beats produce no output.
  - The accumulator clears after the last beat is accepted.
- A single-beat tile (in_last on the first beat) in mode 1 is identical to mode 0.
- acc_mode changes mid-tile are ignored until the next tile starts.
- Back-to-back beats sustain 1 beat/cycle throughput when out_ready=1.
- Reset mid-operation: in-flight results and the open accumulation are discarded and weights are invalidated. Reload is required.

Test Plan:
- Load W=diag(3,2,5) as rows 2,0,1 (out of order); in=[2,5,6], mode 0 -> weights_loaded=1 after third write; out=[6,10,30] exactly LATENCY cycles after accept, out_last mirrors in_last.
- W=diag(3,2,5), in=[0x04,0x8F,0x18], ACC_SIZE=8 -> out=[12,0x1E,0x78]; with in=[0x00,0x85,0x00] -> out[1]=0x0A (wrap of 0x10A).
- Mode 1, W=identity, beats [1,1,1],[4,3,255],[3,5,3](last) -> single output [8,9,3] with out_last=1; no out_valid for the first two beats.
- Hold out_ready=0 for 5 cycles with 3 beats in flight -> in_ready=0, out_data stable; release -> 3 outputs on consecutive cycles, none lost or duplicated.
- Attempt a weight write with a beat in flight -> w_ready=0 until out_valid drains; then rewrite row 0 to [1,1,1] -> next beat [1,0,0] yields [1,1,1].
- Assert rst_n=0 mid mode-1 tile -> out_valid=0 immediately, weights_loaded=0, in_ready=0; after release, no stale output appears.

Source files
------------

// File: rtl/sa_gemm_ref_model_if.sv
// Handshake bundle between a GEMM tile driver and the reference model:
// weight-row writes, activation beats and result beats.
interface sa_gemm_ref_model_if #(
   parameter int SA_SIZE                = 3,
   parameter int WEIGHT_ACTIVATION_SIZE = 8,
   parameter int ACC_SIZE               = 8
);
   localparam int IDX_W = (SA_SIZE > 1) ? $clog2(SA_SIZE) : 1;

   logic                                             w_valid;
   logic                                             w_ready;
   logic [IDX_W-1:0]                                 w_row_idx;
   logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]   w_row;

   logic                                             in_valid;
   logic                                             in_ready;
   logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]   in_data;
   logic                                             in_last;
   logic                                             acc_mode;

   logic                                             out_valid;
   logic                                             out_ready;
   logic [SA_SIZE-1:0][ACC_SIZE-1:0]                 out_data;
   logic                                             out_last;

   logic                                             weights_loaded;

   modport master (
      output w_valid, w_row_idx, w_row, in_valid, in_data, in_last, acc_mode, out_ready,
      input  w_ready, in_ready, out_valid, out_data, out_last, weights_loaded
   );

   modport slave (
      input  w_valid, w_row_idx, w_row, in_valid, in_data, in_last, acc_mode, out_ready,
      output w_ready, in_ready, out_valid, out_data, out_last, weights_loaded
   );
endinterface

// File: rtl/sa_gemm_ref_model.sv
// Cycle-accurate golden model of a weight-stationary systolic GEMM tile:
// out[i] = sum_j in[j]*W[j][i], mod 2^ACC_SIZE, fixed LATENCY pipeline.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_EMPTY   | no weight row written since reset
// ST_LOADING | some rows written, waiting for the rest (any order)
// ST_READY   | all rows written; activations accepted, weights_loaded=1
module sa_gemm_ref_model #(
   parameter int SA_SIZE                = 3,
   parameter int WEIGHT_ACTIVATION_SIZE = 8,
   parameter int ACC_SIZE               = 8,
   parameter int LATENCY                = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   sa_gemm_ref_model_if.slave  bus
);
   localparam int WAS       = WEIGHT_ACTIVATION_SIZE;
   localparam int IDX_W     = (SA_SIZE > 1) ? $clog2(SA_SIZE) : 1;
   // full-width products plus headroom for SA_SIZE additions
   localparam int SUM_RAW_W = 2 * WAS + IDX_W;
   localparam int SUM_W     = (SUM_RAW_W > ACC_SIZE) ? SUM_RAW_W : ACC_SIZE;

   typedef enum logic [1:0] {ST_EMPTY, ST_LOADING, ST_READY} state_t;
   typedef logic [SA_SIZE-1:0][ACC_SIZE-1:0] vec_t;

   state_t                                           state_q, state_d;
   logic [SA_SIZE-1:0]                               mask_q, mask_d;
   logic [SA_SIZE-1:0][SA_SIZE-1:0][WAS-1:0]         w_q, w_d;
   logic [LATENCY-1:0]                               vld_q, vld_d;
   logic [LATENCY-1:0]                               last_q, last_d;
   logic [LATENCY-1:0][SA_SIZE-1:0][ACC_SIZE-1:0]    data_q, data_d;
   vec_t                                             acc_q, acc_d;
   logic                                             tile_open_q, tile_open_d;
   logic                                             tile_mode_q, tile_mode_d;

   vec_t                                             dot;
   vec_t                                             sum;
   logic [SUM_W-1:0]                                 lane_sum;
   logic                                             stall;
   logic                                             w_fire;
   logic                                             in_fire;
   logic                                             w_idx_oob;
   logic                                             beat_mode;

   assign stall              = vld_q[LATENCY-1] && !bus.out_ready;
   assign bus.in_ready       = (state_q == ST_READY) && !stall;
   // weights may only change with nothing in flight and no accumulation open
   assign bus.w_ready        = (vld_q == '0) && !(tile_open_q && tile_mode_q);
   assign bus.out_valid      = vld_q[LATENCY-1];
   assign bus.out_data       = data_q[LATENCY-1];
   assign bus.out_last       = last_q[LATENCY-1];
   assign bus.weights_loaded = (state_q == ST_READY);

   assign w_fire    = bus.w_valid && bus.w_ready;
   assign in_fire   = bus.in_valid && bus.in_ready;
   // assertion target: out-of-range row writes still handshake but are dropped
   assign w_idx_oob = (int'(bus.w_row_idx) >= SA_SIZE);
   // acc_mode only counts on the first beat of a tile
   assign beat_mode = tile_open_q ? tile_mode_q : bus.acc_mode;

   // per-lane dot product with current weights, and running tile sum
   always_comb begin
      dot      = '0;
      sum      = '0;
      lane_sum = '0;
      for (int i = 0; i < SA_SIZE; i++) begin
         lane_sum = '0;
         for (int j = 0; j < SA_SIZE; j++) begin
            lane_sum = lane_sum + SUM_W'(bus.in_data[j]) * SUM_W'(w_q[j][i]);
         end
         dot[i] = lane_sum[ACC_SIZE-1:0];
         sum[i] = acc_q[i] + lane_sum[ACC_SIZE-1:0];
      end
   end

   // next-state: weight load FSM, pipeline shift, tile accumulation
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      w_d         = w_q;
      vld_d       = vld_q;
      last_d      = last_q;
      data_d      = data_q;
      acc_d       = acc_q;
      tile_open_d = tile_open_q;
      tile_mode_d = tile_mode_q;

      if (w_fire && !w_idx_oob) begin
         w_d[bus.w_row_idx]    = bus.w_row;
         mask_d[bus.w_row_idx] = 1'b1;
      end
      if (&mask_d) begin
         state_d = ST_READY;
      end else if (mask_d != '0) begin
         state_d = ST_LOADING;
      end

      if (!stall) begin
         for (int k = LATENCY - 1; k > 0; k--) begin
            vld_d[k]  = vld_q[k-1];
            last_d[k] = last_q[k-1];
            data_d[k] = data_q[k-1];
         end
         vld_d[0]  = 1'b0;
         last_d[0] = 1'b0;
         data_d[0] = '0;
         if (in_fire) begin
            tile_open_d = !bus.in_last;
            tile_mode_d = beat_mode;
            if (beat_mode) begin
               acc_d = bus.in_last ? '0 : sum;
               if (bus.in_last) begin
                  vld_d[0]  = 1'b1;
                  last_d[0] = 1'b1;
                  data_d[0] = sum;
               end
            end else begin
               vld_d[0]  = 1'b1;
               last_d[0] = bus.in_last;
               data_d[0] = dot;
            end
         end
      end
   end

   // state register; reset discards weights, in-flight results and accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         mask_q      <= '0;
         w_q         <= '0;
         vld_q       <= '0;
         last_q      <= '0;
         data_q      <= '0;
         acc_q       <= '0;
         tile_open_q <= 1'b0;
         tile_mode_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         w_q         <= w_d;
         vld_q       <= vld_d;
         last_q      <= last_d;
         data_q      <= data_d;
         acc_q       <= acc_d;
         tile_open_q <= tile_open_d;
         tile_mode_q <= tile_mode_d;
      end
   end
endmodule

// File: tb/tb_sa_gemm_ref_model.sv
// Directed bench for sa_gemm_ref_model: weight loading, latency, wrap,
// tile accumulation, back-pressure, weight-write gating and mid-tile reset.
module tb_sa_gemm_ref_model;
   localparam int SA  = 3;
   localparam int WAS = 8;
   localparam int ACC = 8;
   localparam int LAT = 2;

   typedef logic [SA-1:0][7:0] vec_t;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;

   sa_gemm_ref_model_if #(.SA_SIZE(SA), .WEIGHT_ACTIVATION_SIZE(WAS), .ACC_SIZE(ACC)) bus ();

   sa_gemm_ref_model #(
      .SA_SIZE(SA), .WEIGHT_ACTIVATION_SIZE(WAS), .ACC_SIZE(ACC), .LATENCY(LAT)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic vec_t v3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      vec_t r;
      r[0] = a;
      r[1] = b;
      r[2] = c;
      return r;
   endfunction

   task automatic wr_row(input logic [1:0] idx, input vec_t row);
      bus.w_valid   = 1'b1;
      bus.w_row_idx = idx;
      bus.w_row     = row;
      chk("w_ready", 32'(bus.w_ready), 32'd1);
      @(negedge clk);
      bus.w_valid = 1'b0;
   endtask

   task automatic load_identity();
      wr_row(2'd0, v3(1, 0, 0));
      wr_row(2'd1, v3(0, 1, 0));
      wr_row(2'd2, v3(0, 0, 1));
   endtask

   // one beat, then its result must appear exactly LAT cycles after accept
   task automatic beat_chk(input string tag, input vec_t d, input logic last, input logic mode,
                           input vec_t exp, input logic exp_last);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      bus.acc_mode = mode;
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int k = 1; k < LAT; k++) begin
         chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
         @(negedge clk);
      end
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_data"}, 32'(bus.out_data), 32'(exp));
      chk({tag, "_last"}, 32'(bus.out_last), 32'(exp_last));
      @(negedge clk);
      chk({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      n_chk         = 0;
      n_pass        = 0;
      rst_n         = 1'b0;
      bus.w_valid   = 1'b0;
      bus.w_row_idx = '0;
      bus.w_row     = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.acc_mode  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_out_last", 32'(bus.out_last), 32'd0);
      chk("rst_loaded", 32'(bus.weights_loaded), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_w_ready", 32'(bus.w_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // diag(3,2,5) loaded out of order: rows 2, 0, 1
      wr_row(2'd2, v3(0, 0, 5));
      chk("load_partial", 32'(bus.weights_loaded), 32'd0);
      chk("load_partial_in_ready", 32'(bus.in_ready), 32'd0);
      wr_row(2'd0, v3(3, 0, 0));
      wr_row(2'd1, v3(0, 2, 0));
      chk("load_done", 32'(bus.weights_loaded), 32'd1);

      beat_chk("diag", v3(2, 5, 6), 1'b1, 1'b0, v3(6, 10, 30), 1'b1);
      beat_chk("diag_nolast", v3(8'h04, 8'h8F, 8'h18), 1'b0, 1'b0, v3(12, 8'h1E, 8'h78), 1'b0);
      beat_chk("wrap", v3(8'h00, 8'h85, 8'h00), 1'b1, 1'b0, v3(0, 8'h0A, 0), 1'b1);

      // tile accumulate, identity weights; acc_mode drops mid-tile and is ignored
      load_identity();
      bus.in_valid = 1'b1;
      bus.in_data  = v3(1, 1, 1);
      bus.in_last  = 1'b0;
      bus.acc_mode = 1'b1;
      @(negedge clk);
      chk("acc_b1_no_out", 32'(bus.out_valid), 32'd0);
      chk("acc_open_w_ready", 32'(bus.w_ready), 32'd0);
      bus.in_data  = v3(4, 3, 255);
      bus.acc_mode = 1'b0;
      @(negedge clk);
      chk("acc_b2_no_out", 32'(bus.out_valid), 32'd0);
      bus.in_data = v3(3, 5, 3);
      bus.in_last = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("acc_b3_early", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk("acc_valid", 32'(bus.out_valid), 32'd1);
      chk("acc_data", 32'(bus.out_data), 32'(v3(8, 9, 3)));
      chk("acc_last", 32'(bus.out_last), 32'd1);
      @(negedge clk);
      chk("acc_drain", 32'(bus.out_valid), 32'd0);
      chk("acc_closed_w_ready", 32'(bus.w_ready), 32'd1);

      // back-pressure: out_ready low for 5 cycles with the pipeline full
      bus.out_ready = 1'b0;
      bus.acc_mode  = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = v3(1, 2, 3);
      bus.in_last   = 1'b0;
      @(negedge clk);
      chk("stall_b2_in_ready", 32'(bus.in_ready), 32'd1);
      bus.in_data = v3(4, 5, 6);
      @(negedge clk);
      bus.in_data = v3(7, 8, 9);
      bus.in_last = 1'b1;
      for (int c = 0; c < 5; c++) begin
         chk("stall_valid", 32'(bus.out_valid), 32'd1);
         chk("stall_data", 32'(bus.out_data), 32'(v3(1, 2, 3)));
         chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
         if (c < 4) @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("rel_o2_valid", 32'(bus.out_valid), 32'd1);
      chk("rel_o2_data", 32'(bus.out_data), 32'(v3(4, 5, 6)));
      chk("rel_o2_last", 32'(bus.out_last), 32'd0);
      @(negedge clk);
      chk("rel_o3_valid", 32'(bus.out_valid), 32'd1);
      chk("rel_o3_data", 32'(bus.out_data), 32'(v3(7, 8, 9)));
      chk("rel_o3_last", 32'(bus.out_last), 32'd1);
      @(negedge clk);
      chk("rel_drain", 32'(bus.out_valid), 32'd0);

      // weight write requested while a beat is in flight
      bus.in_valid = 1'b1;
      bus.in_data  = v3(2, 3, 4);
      bus.in_last  = 1'b1;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.w_valid   = 1'b1;
      bus.w_row_idx = 2'd0;
      bus.w_row     = v3(1, 1, 1);
      chk("wgate_s0_w_ready", 32'(bus.w_ready), 32'd0);
      @(negedge clk);
      chk("wgate_out_valid", 32'(bus.out_valid), 32'd1);
      chk("wgate_out_data", 32'(bus.out_data), 32'(v3(2, 3, 4)));
      chk("wgate_s1_w_ready", 32'(bus.w_ready), 32'd0);
      @(negedge clk);
      chk("wgate_drained_w_ready", 32'(bus.w_ready), 32'd1);
      @(negedge clk);
      bus.w_valid = 1'b0;
      beat_chk("new_row0", v3(1, 0, 0), 1'b1, 1'b0, v3(1, 1, 1), 1'b1);

      // out-of-range row index: handshakes, changes nothing
      wr_row(2'd3, v3(9, 9, 9));
      chk("oob_loaded", 32'(bus.weights_loaded), 32'd1);
      beat_chk("oob_row2", v3(0, 0, 1), 1'b1, 1'b0, v3(0, 0, 1), 1'b1);

      // reset in the middle of a mode-1 tile with a result at the output
      bus.in_valid = 1'b1;
      bus.in_data  = v3(5, 5, 5);
      bus.in_last  = 1'b1;
      bus.acc_mode = 1'b0;
      @(negedge clk);
      bus.in_data  = v3(1, 1, 1);
      bus.in_last  = 1'b0;
      bus.acc_mode = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("prerst_valid", 32'(bus.out_valid), 32'd1);
      chk("prerst_data", 32'(bus.out_data), 32'(v3(5, 10, 10)));
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_loaded", 32'(bus.weights_loaded), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("postrst_no_stale", 32'(bus.out_valid), 32'd0);
      end
      chk("postrst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("postrst_w_ready", 32'(bus.w_ready), 32'd1);
      load_identity();
      chk("reload_done", 32'(bus.weights_loaded), 32'd1);
      beat_chk("single_acc", v3(2, 3, 4), 1'b1, 1'b1, v3(2, 3, 4), 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
